// File: rtl/dcache_wb_param.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU word port and block-wide memory.
// Hits complete with zero stall; misses stall the CPU through write-back, refill and line update.
module dcache_wb_param #(
  parameter  int ADDR_W    = 8,
  parameter  int DATA_W    = 8,
  parameter  int WPB       = 4,
  parameter  int NUM_LINES = 8,
  localparam int OFF_W     = $clog2(WPB),
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_busywait,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  output logic [DATA_W*WPB-1:0]   mem_wdata,
  input  logic [DATA_W*WPB-1:0]   mem_rdata,
  input  logic                    mem_busywait
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

  state_t                        r_state;
  logic [WPB-1:0][DATA_W-1:0]    r_data [NUM_LINES];
  logic [TAG_W-1:0]              r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0]          r_valid;
  logic [NUM_LINES-1:0]          r_dirty;
  logic                          r_issued;
  logic [WPB-1:0][DATA_W-1:0]    r_fill;

  logic [OFF_W-1:0]              w_off;
  logic [IDX_W-1:0]              w_idx;
  logic [TAG_W-1:0]              w_tag;
  logic                          w_req;
  logic                          w_hit;
  logic                          w_idle_hit;

  always_comb begin
    w_off        = cpu_addr[OFF_W-1:0];
    w_idx        = cpu_addr[OFF_W +: IDX_W];
    w_tag        = cpu_addr[ADDR_W-1 -: TAG_W];
    w_req        = cpu_read | cpu_write;
    w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_idle_hit   = (r_state == IDLE) && w_hit;
    cpu_busywait = w_req && !w_idle_hit;
    // A simultaneous read+write is a write, so no read data is returned for it
    cpu_rdata    = '0;
    if (w_idle_hit && cpu_read && !cpu_write)
      cpu_rdata = r_data[w_idx][w_off];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_valid   <= '0;
      r_dirty   <= '0;
      r_issued  <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              if (cpu_write) begin
                r_data[w_idx][w_off] <= cpu_wdata;
                r_dirty[w_idx]       <= 1'b1;
              end
            end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
              r_state   <= WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {r_tag[w_idx], w_idx};
              mem_wdata <= r_data[w_idx];
            end else begin
              r_state  <= ALLOCATE;
              mem_read <= 1'b1;
              mem_addr <= {w_tag, w_idx};
            end
          end
        end
        // The first edge in a memory state only marks the request issued; completion
        // is recognised from the second edge on, once memory is no longer busy.
        WRITEBACK: begin
          if (!r_issued) begin
            r_issued <= 1'b1;
          end else if (!mem_busywait) begin
            r_issued  <= 1'b0;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= {w_tag, w_idx};
            r_state   <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (!r_issued) begin
            r_issued <= 1'b1;
          end else if (!mem_busywait) begin
            r_issued <= 1'b0;
            mem_read <= 1'b0;
            r_fill   <= mem_rdata;
            r_state  <= UPDATE;
          end
        end
        UPDATE: begin
          r_data[w_idx]  <= r_fill;
          r_tag[w_idx]   <= w_tag;
          r_valid[w_idx] <= 1'b1;
          r_dirty[w_idx] <= 1'b0;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
